// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution tap iterator:
//   - default layer dimensions (the full-size layer the iterator was built for)
//   - IDLE/RUN state encoding
//   - tap-descriptor field widths, expressed relative to the index width W
// -----------------------------------------------------------------------------
package conv_pkg;

   // Default layer dimensions
   localparam int DEF_W          = 8;
   localparam int DEF_DIM_IMG    = 32;
   localparam int DEF_DIM_OUT    = 32;
   localparam int DEF_DIM_KERNEL = 5;
   localparam int DEF_IN_CH      = 3;
   localparam int DEF_OUT_CH     = 32;
   localparam int DEF_STRIDE     = 1;
   localparam int DEF_PADDING    = 2;

   // Iterator state
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // in_row/in_col are W+1 bits signed; they are evaluated in W+2 bits so
   // that STRIDE*index + ker - PADDING cannot overflow before truncation.
   localparam int COORD_EXTRA = 1;
   localparam int CALC_EXTRA  = 2;

endpackage

// File: rtl/conv_tap_iter_if.sv
// -----------------------------------------------------------------------------
// conv_tap_iter_if
// Handshake and tap-descriptor bundle between the layer controller, the
// iterator and the MAC/accumulator datapath.
//   start            controller -> iterator, start pulse
//   ready            datapath   -> iterator, accepts current tap
//   valid            iterator   -> datapath, tap descriptor valid
//   out_ch/out_row/out_col, ker_row/ker_col/in_ch   loop indices (W bits)
//   in_row/in_col    signed input-image coordinate (W+1 bits)
//   in_bounds        coordinate lies inside the image
//   first/last       window markers
//   busy/done        iterator status
// Modports: master = iterator side, slave = controller/datapath side.
// -----------------------------------------------------------------------------
interface conv_tap_iter_if
   import conv_pkg::*;
#(
   parameter int W = DEF_W
) ();

   logic                         start;
   logic                         ready;
   logic                         valid;
   logic [W-1:0]                 out_ch;
   logic [W-1:0]                 out_row;
   logic [W-1:0]                 out_col;
   logic [W-1:0]                 ker_row;
   logic [W-1:0]                 ker_col;
   logic [W-1:0]                 in_ch;
   logic signed [W+COORD_EXTRA-1:0] in_row;
   logic signed [W+COORD_EXTRA-1:0] in_col;
   logic                         in_bounds;
   logic                         first;
   logic                         last;
   logic                         busy;
   logic                         done;

   modport master (
      input  start, ready,
      output valid, out_ch, out_row, out_col, ker_row, ker_col, in_ch,
             in_row, in_col, in_bounds, first, last, busy, done
   );

   modport slave (
      output start, ready,
      input  valid, out_ch, out_row, out_col, ker_row, ker_col, in_ch,
             in_row, in_col, in_bounds, first, last, busy, done
   );

endinterface

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// W-bit modulo-LIMIT counter used as one level of the loop nest.
//   clk, reset  clock, asynchronous active-high reset
//   inc         advance by one
//   clr         synchronous clear to 0 (has priority over inc)
//   value       current count
//   wrap        inc while value == LIMIT-1; carry into the next level
// -----------------------------------------------------------------------------
module wrap_counter #(
   parameter int W     = 8,
   parameter int LIMIT = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   // NOTE: the default assignment first keeps every path assigned, so no latch.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc) begin
         value_d = (value_q == LAST) ? '0 : value_q + W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) value_q <= '0;
      else       value_q <= value_d;
   end

   assign value = value_q;
   assign wrap  = inc && (value_q == LAST);

endmodule

// File: rtl/conv_tap_iter.sv
// -----------------------------------------------------------------------------
// conv_tap_iter
// Convolution loop-nest iterator. Walks (out_ch, out_row, out_col, ker_row,
// ker_col, in_ch), innermost last in that list, and emits one registered tap
// descriptor per cycle over a valid/ready handshake.
//   clk    clock, rising edge
//   reset  asynchronous, active-high reset
//   tap    conv_tap_iter_if.master: start/ready in; descriptor, busy, done out
//
// Build option: CONV_ITER_SKIP_PAD_EN
//   undefined - every tap is emitted, padding taps carry in_bounds=0
//   defined   - out-of-bounds taps are stepped over internally (one per cycle,
//               independent of ready); the window's last tap is always emitted
//
// Structure: the six counters hold the next candidate tap. A candidate is
// either loaded into the output registers (when the output slot is empty or
// being handshaken) or, with skipping enabled, dropped. After the final
// candidate is taken, the handshake of the tap in the output slot ends the run.
// -----------------------------------------------------------------------------
module conv_tap_iter
   import conv_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int DIM_IMG    = DEF_DIM_IMG,
   parameter int DIM_OUT    = DEF_DIM_OUT,
   parameter int DIM_KERNEL = DEF_DIM_KERNEL,
   parameter int IN_CH      = DEF_IN_CH,
   parameter int OUT_CH     = DEF_OUT_CH,
   parameter int STRIDE     = DEF_STRIDE,
   parameter int PADDING    = DEF_PADDING
) (
   input logic             clk,
   input logic             reset,
   conv_tap_iter_if.master tap
);

   localparam int CW = W + CALC_EXTRA;
   localparam int OW = W + COORD_EXTRA;

   localparam logic signed [CW-1:0] STRIDE_S = CW'(STRIDE);
   localparam logic signed [CW-1:0] PAD_S    = CW'(PADDING);
   localparam logic signed [CW-1:0] DIM_S    = CW'(DIM_IMG);
   localparam logic [W-1:0]         K_LAST   = W'(DIM_KERNEL - 1);
   localparam logic [W-1:0]         IC_LAST  = W'(IN_CH - 1);

   // Candidate counters and their carries
   logic [W-1:0] ic_cnt, kc_cnt, kr_cnt, ocl_cnt, orw_cnt, oc_cnt;
   logic         ic_wrap, kc_wrap, kr_wrap, ocl_wrap, orw_wrap, oc_wrap;

   // Control state
   state_e state_q;
   logic   cand_valid_q;   // counters hold a tap not yet taken
   logic   first_pend_q;   // window started, no tap of it emitted yet
   logic   valid_q, busy_q, done_q;

   // Output descriptor registers
   logic [W-1:0]         oc_q, orw_q, ocl_q, kr_q, kc_q, ic_q;
   logic signed [OW-1:0] in_row_q, in_col_q;
   logic                 inb_q, first_q, last_q;

   // Candidate decode
   logic signed [CW-1:0] row_full, col_full;
   logic                 cand_inb, cand_last, cand_first;
   logic                 out_free, skip, load, adv, clr;

   assign clr = (state_q == ST_IDLE) && tap.start;

   wrap_counter #(.W(W), .LIMIT(IN_CH)) u_ic (
      .clk(clk), .reset(reset), .inc(adv), .clr(clr),
      .value(ic_cnt), .wrap(ic_wrap)
   );
   wrap_counter #(.W(W), .LIMIT(DIM_KERNEL)) u_kc (
      .clk(clk), .reset(reset), .inc(ic_wrap), .clr(clr),
      .value(kc_cnt), .wrap(kc_wrap)
   );
   wrap_counter #(.W(W), .LIMIT(DIM_KERNEL)) u_kr (
      .clk(clk), .reset(reset), .inc(kc_wrap), .clr(clr),
      .value(kr_cnt), .wrap(kr_wrap)
   );
   wrap_counter #(.W(W), .LIMIT(DIM_OUT)) u_ocl (
      .clk(clk), .reset(reset), .inc(kr_wrap), .clr(clr),
      .value(ocl_cnt), .wrap(ocl_wrap)
   );
   wrap_counter #(.W(W), .LIMIT(DIM_OUT)) u_orw (
      .clk(clk), .reset(reset), .inc(ocl_wrap), .clr(clr),
      .value(orw_cnt), .wrap(orw_wrap)
   );
   wrap_counter #(.W(W), .LIMIT(OUT_CH)) u_oc (
      .clk(clk), .reset(reset), .inc(orw_wrap), .clr(clr),
      .value(oc_cnt), .wrap(oc_wrap)
   );

   // Input coordinates in wide signed math; indices are zero-extended first.
   assign row_full = STRIDE_S * signed'(CW'(orw_cnt)) + signed'(CW'(kr_cnt)) - PAD_S;
   assign col_full = STRIDE_S * signed'(CW'(ocl_cnt)) + signed'(CW'(kc_cnt)) - PAD_S;

   assign cand_inb   = (row_full >= 0) && (row_full < DIM_S) &&
                       (col_full >= 0) && (col_full < DIM_S);
   assign cand_last  = (kr_cnt == K_LAST) && (kc_cnt == K_LAST) && (ic_cnt == IC_LAST);
   // The window-start condition is folded into the sticky flag so a skipped
   // window-start tap still marks the next emitted tap as first.
   assign cand_first = first_pend_q ||
                       ((kr_cnt == '0) && (kc_cnt == '0) && (ic_cnt == '0));

   assign out_free = !valid_q || tap.ready;

`ifdef CONV_ITER_SKIP_PAD_EN
   assign skip = cand_valid_q && !cand_inb && !cand_last;
`else
   assign skip = 1'b0;
`endif

   assign load = cand_valid_q && !skip && out_free;
   assign adv  = skip || load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cand_valid_q <= 1'b0;
         first_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         oc_q         <= '0;
         orw_q        <= '0;
         ocl_q        <= '0;
         kr_q         <= '0;
         kc_q         <= '0;
         ic_q         <= '0;
         in_row_q     <= '0;
         in_col_q     <= '0;
         inb_q        <= 1'b0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (tap.start) begin
                  state_q      <= ST_RUN;
                  busy_q       <= 1'b1;
                  cand_valid_q <= 1'b1;
                  first_pend_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (load) begin
                  valid_q  <= 1'b1;
                  oc_q     <= oc_cnt;
                  orw_q    <= orw_cnt;
                  ocl_q    <= ocl_cnt;
                  kr_q     <= kr_cnt;
                  kc_q     <= kc_cnt;
                  ic_q     <= ic_cnt;
                  in_row_q <= row_full[OW-1:0];
                  in_col_q <= col_full[OW-1:0];
                  inb_q    <= cand_inb;
                  first_q  <= cand_first;
                  last_q   <= cand_last;
               end else if (valid_q && tap.ready) begin
                  valid_q <= 1'b0;
                  // Slot drained with no candidate left: that was the final tap.
                  if (!cand_valid_q) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               if (adv) begin
                  // Carry out of the outermost counter means the final tap was
                  // just taken; the counters have already wrapped back to 0.
                  cand_valid_q <= !oc_wrap;
                  first_pend_q <= skip ? cand_first : 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tap.valid     = valid_q;
   assign tap.out_ch    = oc_q;
   assign tap.out_row   = orw_q;
   assign tap.out_col   = ocl_q;
   assign tap.ker_row   = kr_q;
   assign tap.ker_col   = kc_q;
   assign tap.in_ch     = ic_q;
   assign tap.in_row    = in_row_q;
   assign tap.in_col    = in_col_q;
   assign tap.in_bounds = inb_q;
   assign tap.first     = first_q;
   assign tap.last      = last_q;
   assign tap.busy      = busy_q;
   assign tap.done      = done_q;

endmodule

// File: tb/tb_conv_tap_iter.sv
// -----------------------------------------------------------------------------
// tb_conv_tap_iter
// Self-checking bench for conv_tap_iter with a small layer
// (4x4 image and output, 3x3 kernel, 2 in / 2 out channels, stride 1, pad 1).
// Expected tap streams come from a nested-loop reference and from a table of
// hand-computed descriptors at selected beats. Works with or without
// CONV_ITER_SKIP_PAD_EN defined.
// -----------------------------------------------------------------------------
module tb_conv_tap_iter;

   localparam int W       = 8;
   localparam int DIM_IMG = 4;
   localparam int DIM_OUT = 4;
   localparam int K       = 3;
   localparam int IC      = 2;
   localparam int OC      = 2;
   localparam int S       = 1;
   localparam int P       = 1;

`ifdef CONV_ITER_SKIP_PAD_EN
   localparam int EXP_BEATS       = 414;
   localparam int EXP_FIRST_CYCLE = 9;
`else
   localparam int EXP_BEATS       = 576;
   localparam int EXP_FIRST_CYCLE = 1;
`endif
   localparam int EXP_DONE_CYCLE = 577;
   localparam int BUDGET         = 3000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   conv_tap_iter_if #(.W(W)) tap ();

   conv_tap_iter #(
      .W(W), .DIM_IMG(DIM_IMG), .DIM_OUT(DIM_OUT), .DIM_KERNEL(K),
      .IN_CH(IC), .OUT_CH(OC), .STRIDE(S), .PADDING(P)
   ) dut (
      .clk(clk),
      .reset(reset),
      .tap(tap)
   );

   always #5 clk = ~clk;

   typedef struct {
      int oc, orw, ocl, kr, kc, ic, ir, icl;
      bit inb, first, last;
   } tap_t;

   typedef struct {
      int   beat;
      tap_t exp;
   } vec_t;

   tap_t exp_q[$];
   vec_t vecs[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input bit ok, input string got_s, input string exp_s);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got %s, expected %s", name, got_s, exp_s);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      check(name, got == exp, $sformatf("%0d", got), $sformatf("%0d", exp));
   endtask

   function automatic tap_t mk(input int oc, orw, ocl, kr, kc, ic, ir, icl,
                               input bit inb, first, last);
      tap_t t;
      t.oc = oc; t.orw = orw; t.ocl = ocl; t.kr = kr; t.kc = kc; t.ic = ic;
      t.ir = ir; t.icl = icl; t.inb = inb; t.first = first; t.last = last;
      return t;
   endfunction

   function automatic string tap_str(input tap_t t);
      return $sformatf("out(%0d,%0d,%0d) ker(%0d,%0d) ic%0d in(%0d,%0d) inb=%0b first=%0b last=%0b",
                       t.oc, t.orw, t.ocl, t.kr, t.kc, t.ic, t.ir, t.icl, t.inb, t.first, t.last);
   endfunction

   function automatic bit tap_eq(input tap_t a, input tap_t b);
      return a.oc == b.oc && a.orw == b.orw && a.ocl == b.ocl && a.kr == b.kr &&
             a.kc == b.kc && a.ic == b.ic && a.ir == b.ir && a.icl == b.icl &&
             a.inb == b.inb && a.first == b.first && a.last == b.last;
   endfunction

   function automatic tap_t sample();
      tap_t t;
      t.oc    = int'(tap.out_ch);
      t.orw   = int'(tap.out_row);
      t.ocl   = int'(tap.out_col);
      t.kr    = int'(tap.ker_row);
      t.kc    = int'(tap.ker_col);
      t.ic    = int'(tap.in_ch);
      t.ir    = $signed(tap.in_row);
      t.icl   = $signed(tap.in_col);
      t.inb   = tap.in_bounds;
      t.first = tap.first;
      t.last  = tap.last;
      return t;
   endfunction

   task automatic check_tap(input string name, input tap_t got, input tap_t exp);
      check(name, tap_eq(got, exp), tap_str(got), tap_str(exp));
   endtask

   // Reference stream: plain nested loops over the layer.
   function automatic void build_model();
      tap_t t;
      bit   fresh, emit;
      for (int oc = 0; oc < OC; oc++)
         for (int orw = 0; orw < DIM_OUT; orw++)
            for (int ocl = 0; ocl < DIM_OUT; ocl++) begin
               fresh = 1'b1;
               for (int kr = 0; kr < K; kr++)
                  for (int kc = 0; kc < K; kc++)
                     for (int ic = 0; ic < IC; ic++) begin
                        t.oc = oc; t.orw = orw; t.ocl = ocl;
                        t.kr = kr; t.kc = kc; t.ic = ic;
                        t.ir  = S * orw + kr - P;
                        t.icl = S * ocl + kc - P;
                        t.inb = (t.ir >= 0) && (t.ir < DIM_IMG) && (t.icl >= 0) && (t.icl < DIM_IMG);
                        t.last = (kr == K - 1) && (kc == K - 1) && (ic == IC - 1);
`ifdef CONV_ITER_SKIP_PAD_EN
                        emit = t.inb || t.last;
`else
                        emit = 1'b1;
`endif
                        if (emit) begin
                           t.first = fresh;
                           fresh   = 1'b0;
                           exp_q.push_back(t);
                        end
                     end
            end
   endfunction

   task automatic add_vec(input int beat, input tap_t e);
      vec_t v;
      v.beat = beat;
      v.exp  = e;
      vecs.push_back(v);
   endtask

   // One complete job. stall_beat>0 holds ready low for 3 cycles while that
   // beat is presented; restart_beat>0 pulses start once after that beat.
   task automatic run_job(input string tag, input int stall_beat, input int restart_beat,
                          input bit use_table, output int beats, output int dones,
                          output int first_cycle, output int done_cycle);
      tap_t got, held;
      int   stall_left;
      bit   finished, restarted;
      beats = 0; dones = 0; first_cycle = -1; done_cycle = -1;
      stall_left = 3; finished = 1'b0; restarted = 1'b0;
      held = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      tap.start = 1'b1;
      tap.ready = 1'b1;
      @(negedge clk);
      tap.start = 1'b0;
      check({tag, " run state after start edge"}, tap.busy === 1'b1 && tap.valid === 1'b0,
            $sformatf("busy=%0b valid=%0b", tap.busy, tap.valid), "busy=1 valid=0");

      for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
         @(negedge clk);
         tap.start = 1'b0;
         if (restart_beat > 0 && !restarted && beats >= restart_beat) begin
            tap.start = 1'b1;
            restarted = 1'b1;
         end
         tap.ready = 1'b1;
         if (tap.valid === 1'b1) begin
            got = sample();
            if (first_cycle < 0) first_cycle = cyc;
            if (stall_beat > 0 && beats + 1 == stall_beat) begin
               if (stall_left == 3) held = got;
               else check_tap($sformatf("%s hold beat %0d", tag, stall_beat), got, held);
               if (stall_left > 0) begin
                  tap.ready = 1'b0;
                  stall_left--;
               end
            end
            if (tap.ready) begin
               beats++;
               if (beats <= exp_q.size())
                  check_tap($sformatf("%s beat %0d", tag, beats), got, exp_q[beats-1]);
               else
                  check($sformatf("%s extra beat %0d", tag, beats), 1'b0, tap_str(got), "no beat");
               if (use_table)
                  foreach (vecs[v])
                     if (vecs[v].beat == beats)
                        check_tap($sformatf("%s table beat %0d", tag, beats), got, vecs[v].exp);
            end
         end
         if (tap.done === 1'b1) begin
            dones++;
            if (done_cycle < 0) begin
               done_cycle = cyc;
               check({tag, " idle with done"}, tap.busy === 1'b0 && tap.valid === 1'b0,
                     $sformatf("busy=%0b valid=%0b", tap.busy, tap.valid), "busy=0 valid=0");
            end
         end
         if (done_cycle > 0 && cyc == done_cycle + 1) begin
            check({tag, " done pulse width"}, tap.done === 1'b0,
                  $sformatf("done=%0b", tap.done), "done=0");
            finished = 1'b1;
         end
      end
      tap.start = 1'b0;
      tap.ready = 1'b1;
      check({tag, " completion"}, finished, "timeout", "done within budget");
   endtask

   initial begin
      int beats, dones, fc, dc;
      tap_t got;
      bit   seen;

      build_model();
`ifdef CONV_ITER_SKIP_PAD_EN
      add_vec(1,   mk(0, 0, 0, 1, 1, 0,  0,  0, 1'b1, 1'b1, 1'b0));
      add_vec(2,   mk(0, 0, 0, 1, 1, 1,  0,  0, 1'b1, 1'b0, 1'b0));
      add_vec(8,   mk(0, 0, 0, 2, 2, 1,  1,  1, 1'b1, 1'b0, 1'b1));
      add_vec(9,   mk(0, 0, 1, 1, 0, 0,  0,  0, 1'b1, 1'b1, 1'b0));
      add_vec(207, mk(0, 3, 3, 2, 2, 1,  4,  4, 1'b0, 1'b0, 1'b1));
      add_vec(414, mk(1, 3, 3, 2, 2, 1,  4,  4, 1'b0, 1'b0, 1'b1));
`else
      add_vec(1,   mk(0, 0, 0, 0, 0, 0, -1, -1, 1'b0, 1'b1, 1'b0));
      add_vec(2,   mk(0, 0, 0, 0, 0, 1, -1, -1, 1'b0, 1'b0, 1'b0));
      add_vec(10,  mk(0, 0, 0, 1, 1, 1,  0,  0, 1'b1, 1'b0, 1'b0));
      add_vec(18,  mk(0, 0, 0, 2, 2, 1,  1,  1, 1'b1, 1'b0, 1'b1));
      add_vec(19,  mk(0, 0, 1, 0, 0, 0, -1,  0, 1'b0, 1'b1, 1'b0));
      add_vec(73,  mk(0, 1, 0, 0, 0, 0,  0, -1, 1'b0, 1'b1, 1'b0));
      add_vec(289, mk(1, 0, 0, 0, 0, 0, -1, -1, 1'b0, 1'b1, 1'b0));
      add_vec(576, mk(1, 3, 3, 2, 2, 1,  4,  4, 1'b0, 1'b0, 1'b1));
`endif

      tap.start = 1'b0;
      tap.ready = 1'b1;
      reset     = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      check("reset status", tap.valid === 1'b0 && tap.busy === 1'b0 && tap.done === 1'b0,
            $sformatf("valid=%0b busy=%0b done=%0b", tap.valid, tap.busy, tap.done), "all 0");
      check("reset markers", tap.first === 1'b0 && tap.last === 1'b0 && tap.in_bounds === 1'b0,
            $sformatf("first=%0b last=%0b inb=%0b", tap.first, tap.last, tap.in_bounds), "all 0");
      check_tap("reset descriptor", sample(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0));

      reset = 1'b0;
      @(negedge clk);
      check("idle without start", tap.busy === 1'b0 && tap.valid === 1'b0,
            $sformatf("busy=%0b valid=%0b", tap.busy, tap.valid), "busy=0 valid=0");

      // Full run with ready held high
      run_job("full", 0, 0, 1'b1, beats, dones, fc, dc);
      check_int("full beat count", beats, EXP_BEATS);
      check_int("full done pulses", dones, 1);
      check_int("full first valid cycle", fc, EXP_FIRST_CYCLE);
      check_int("full done cycle", dc, EXP_DONE_CYCLE);

      // Back-pressure on beat 10
      run_job("stall", 10, 0, 1'b0, beats, dones, fc, dc);
      check_int("stall beat count", beats, EXP_BEATS);
      check_int("stall done pulses", dones, 1);

      // start pulsed mid-run must be ignored
      run_job("restart", 0, 50, 1'b0, beats, dones, fc, dc);
      check_int("restart beat count", beats, EXP_BEATS);
      check_int("restart done pulses", dones, 1);
      check_int("restart done cycle", dc, EXP_DONE_CYCLE);

      // Reset in the middle of a run
      @(negedge clk);
      tap.start = 1'b1;
      tap.ready = 1'b1;
      @(negedge clk);
      tap.start = 1'b0;
      beats = 0;
      for (int c = 0; c < BUDGET && beats < 100; c++) begin
         @(negedge clk);
         if (tap.valid === 1'b1 && tap.ready === 1'b1) beats++;
      end
      check_int("mid-run beats before reset", beats, 100);
      #2 reset = 1'b1;
      #1;
      check("async drop on reset", tap.valid === 1'b0 && tap.busy === 1'b0 && tap.done === 1'b0,
            $sformatf("valid=%0b busy=%0b done=%0b", tap.valid, tap.busy, tap.done), "all 0");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("idle after reset release", tap.busy === 1'b0 && tap.valid === 1'b0,
            $sformatf("busy=%0b valid=%0b", tap.busy, tap.valid), "busy=0 valid=0");
      tap.start = 1'b1;
      @(negedge clk);
      tap.start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < BUDGET && !seen; c++) begin
         @(negedge clk);
         if (tap.valid === 1'b1) begin
            got  = sample();
            seen = 1'b1;
            check_tap("first beat after reset", got, exp_q[0]);
         end
      end
      check("restart after reset", seen, "no valid", "valid within budget");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_tap_iter.md
# conv_tap_iter

Parametrised convolution loop-nest iterator, the successor of the single-channel kernel-window counter. It walks output channel, output row, output column, kernel row, kernel column and input channel, and emits one tap descriptor per cycle: indices, the signed input coordinate, an in-bounds flag, and window first/last markers. Emission follows a valid/ready handshake. The block sits between the layer controller (start/done) and the MAC/accumulator datapath, which consumes taps and fetches image/weight operands.

## Interface
- `W`, 8: width of every index counter.
- `DIM_IMG`, 32: input image height/width.
- `DIM_OUT`, 32: output feature-map height/width.
- `DIM_KERNEL`, 5: kernel height/width.
- `IN_CH`, 3: input channels; innermost loop.
- `OUT_CH`, 32: output channels; outermost loop.
- `STRIDE`, 1: convolution stride.
- `PADDING`, 2: zero padding on each side.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: start pulse, sampled in IDLE only.
- `ready` in 1: consumer accepts the current tap.
- `valid` out 1: tap descriptor valid.
- `out_ch`, `out_row`, `out_col` out W: output indices i, j, k.
- `ker_row`, `ker_col`, `in_ch` out W: kernel indices m, n and input channel l.
- `in_row`, `in_col` out W+1 signed: `STRIDE*out_row + ker_row - PADDING`, and the same for columns.
- `in_bounds` out 1: both coordinates are ≥0 and <DIM_IMG.
- `first` out 1: first emitted tap of the current output window.
- `last` out 1: final tap of the window (m=n=DIM_KERNEL-1, l=IN_CH-1).
- `busy` out 1: state is RUN.
- `done` out 1: one-cycle pulse after the final tap.

## Operation
- States: IDLE and RUN.
- IDLE→RUN on `start`. `start` is ignored in RUN.
- Loop order, innermost first: in_ch, ker_col, ker_row, out_col, out_row, out_ch.
- Each counter wraps to 0 at its limit and carries into the next counter.
- The counter set advances only on a handshake (`valid && ready`).
- While `valid && !ready`, every output holds stable.
- On the handshake of the tap with all counters at maximum:
  - RUN→IDLE, counters return to 0.
  - `done`=1 for the next cycle.
- Total taps emitted: OUT_CH·DIM_OUT²·DIM_KERNEL²·IN_CH.
- `first` is a sticky flag:
  - set at window start (m=n=l=0), cleared on the first emitted tap of the window;
  - the output `first` is high on that emitted tap.
- In-bounds arithmetic:
  - Evaluate the coordinates in W+2-bit signed math, then truncate to W+1.
  - Negative coordinates and coordinates ≥DIM_IMG give `in_bounds`=0.
- Reset values:
  - state IDLE, all counters 0;
  - `valid`, `busy`, `done`, `first`, `last` = 0;
  - `in_bounds` = 0;
  - `in_row`/`in_col` = 0.

## Timing
- All outputs are registered.
- Start latency: `start` high at edge N gives `valid` high with tap 0 after edge N+1.
- Throughput: one tap per cycle while `ready` is held high.
- Final handshake at edge M:
  - after M, `valid`=0, `busy`=0, `done`=1;
  - after M+1, `done`=0.
- `start` is accepted in the same cycle that `done` is high, because the state is already IDLE.
- Reset mid-run:
  - `valid`, `busy` and `done` drop asynchronously;
  - the next `start` restarts from tap 0.

## Configuration
- Macro: `CONV_ITER_SKIP_PAD_EN`.
- Undefined: every tap is emitted; padding taps carry `in_bounds`=0, and the consumer multiplies them by zero.
- Defined: out-of-bounds taps advance internally, one per cycle, with `valid`=0.
  - Exception: the window's last tap is always emitted, so the accumulator can save even when that tap is padding.
  - `first` marks the first emitted tap of the window.
  - Skipped cycles do not wait on `ready`.

## Structure
- Shared package `conv_pkg` holds:
  - the default layer dimension constants;
  - the IDLE/RUN state encoding;
  - the tap-descriptor field widths.
- Sub-module `wrap_counter` (W bits, parameter LIMIT):
  - inputs: `inc` and `clr`;
  - outputs: `value` and `wrap` (asserted when `inc` occurs at LIMIT-1);
  - instantiated six times and chained through `wrap`.

## Test plan
Bench parameters for all cases: DIM_IMG=4, DIM_OUT=4, DIM_KERNEL=3, IN_CH=2, OUT_CH=2, STRIDE=1, PADDING=1.

1. Full run, `ready`=1, macro undefined, `start` at cycle 0 → 576 beats on cycles 1–576; `done` on cycle 577; `busy` low from 577.
2. First beat → out(0,0,0), ker(0,0), in_ch 0, `in_row`=`in_col`=-1, `in_bounds`=0, `first`=1, `last`=0.
   - Beat 18 → `last`=1, ker(2,2), in_ch 1.
3. `ready` low for 3 cycles at beat 10 → descriptor held unchanged; total beat count stays 576.
4. Macro defined, `ready`=1:
   - exactly 414 beats (400 in-bounds plus 14 out-of-bounds last taps);
   - window (0,3,3) emits a last beat with `in_row`=`in_col`=4 and `in_bounds`=0.
5. Reset asserted at beat 100 → `valid`/`busy` drop immediately; after release and `start`, the first beat is out(0,0,0) again.
6. `start` pulsed during RUN → ignored; the run completes at 576 beats with a single `done` pulse.
